// File: rtl/stat_frame_packer.sv
// Snapshot FIFO for the statistic outputs. Each snapshot leaves as a 4-byte frame
// (header, parity, grey, trailer) over a valid/ready byte stream.
module stat_frame_packer #(
    parameter int          DEPTH  = 4,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture,
    input  logic [7:0]  EvenParity,
    input  logic [7:0]  GreyCode,
    input  logic        overflow,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        fifo_full,
    output logic [7:0]  drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [7:0] par;
        logic [7:0] gry;
        logic       ovf;
        logic [3:0] seq;
    } entry_t;

    typedef enum logic [2:0] {IDLE, HDR, PAR, GRY, TRL} state_t;

    entry_t          r_mem [DEPTH];
    entry_t          r_hold;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [3:0]      r_seq;
    state_t          r_state;
    logic [7:0]      r_out_data;
    logic            r_out_valid;
    logic            r_out_last;
    logic            r_full;
    logic [7:0]      r_drop;

    logic            w_xfer;
    logic            w_nonempty;
    logic            w_at_depth;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic [CW-1:0]   w_count_next;

    // The full test looks at the registered count, so a same-cycle pop never frees a slot.
    assign w_xfer     = r_out_valid && out_ready;
    assign w_nonempty = (r_count != '0);
    assign w_at_depth = (r_count == CW'(DEPTH));
    assign w_push     = capture && !w_at_depth;
    assign w_drop     = capture && w_at_depth;
    assign w_pop      = w_nonempty && ((r_state == IDLE) || ((r_state == TRL) && w_xfer));

    // NOTE: every signal assigned in always_comb gets a default first, or a latch is inferred.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CW'(1);
        else if (w_pop && !w_push)
            w_count_next = r_count - CW'(1);
    end

    // NOTE: the storage array has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wptr] <= {EvenParity, GreyCode, overflow, r_seq};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_seq       <= 4'd0;
            r_drop      <= 8'd0;
            r_state     <= IDLE;
            r_hold      <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));

            // A capture alongside clear still stores the old seq before it is zeroed.
            if (clear)
                r_seq <= 4'd0;
            else if (w_push)
                r_seq <= r_seq + 4'd1;

            if (clear)
                r_drop <= 8'd0;
            else if (w_drop && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_hold      <= r_mem[r_rptr];
                        r_out_data  <= HEADER;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_state     <= HDR;
                    end
                end
                HDR: begin
                    if (w_xfer) begin
                        r_out_data <= r_hold.par;
                        r_state    <= PAR;
                    end
                end
                PAR: begin
                    if (w_xfer) begin
                        r_out_data <= r_hold.gry;
                        r_state    <= GRY;
                    end
                end
                GRY: begin
                    if (w_xfer) begin
                        r_out_data <= {r_hold.ovf, 3'b000, r_hold.seq};
                        r_out_last <= 1'b1;
                        r_state    <= TRL;
                    end
                end
                TRL: begin
                    if (w_xfer) begin
                        r_out_last <= 1'b0;
                        if (w_pop) begin
                            r_hold     <= r_mem[r_rptr];
                            r_out_data <= HEADER;
                            r_state    <= HDR;
                        end else begin
                            r_out_data  <= 8'h00;
                            r_out_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign fifo_full  = r_full;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_stat_frame_packer.sv
// Directed bench for stat_frame_packer: stimulus pushes expected frame bytes into a
// queue, and an independent monitor pops and compares on every accepted byte.
module tb_stat_frame_packer;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear;
    logic       capture;
    logic [7:0] EvenParity;
    logic [7:0] GreyCode;
    logic       overflow;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       fifo_full;
    logic [7:0] drop_count;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] sb [$];
    logic       prev_stall;
    logic [8:0] prev_byte;

    always #5 clock = ~clock;

    stat_frame_packer #(.DEPTH(4), .HEADER(8'hA5)) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .capture    (capture),
        .EvenParity (EvenParity),
        .GreyCode   (GreyCode),
        .overflow   (overflow),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] par, input logic [7:0] gry, input logic [7:0] trl);
        sb.push_back({1'b0, 8'hA5});
        sb.push_back({1'b0, par});
        sb.push_back({1'b0, gry});
        sb.push_back({1'b1, trl});
    endtask

    task automatic do_capture(input logic [7:0] par, input logic [7:0] gry, input logic ovf,
                              input logic clr);
        capture    = 1'b1;
        EvenParity = par;
        GreyCode   = gry;
        overflow   = ovf;
        clear      = clr;
        tick();
        capture = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        capture = 1'b0;
        clear   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++)
            tick();
        check("drain_remaining", sb.size(), 0);
    endtask

    // Monitor: decisions use values sampled on the falling edge, before the next transfer edge.
    initial begin
        logic [8:0] got;
        logic [8:0] exp;
        prev_stall = 1'b0;
        prev_byte  = '0;
        forever begin
            @(negedge clock);
            if (out_valid) begin
                got = {out_last, out_data};
                if (prev_stall)
                    check("stall_hold", got, prev_byte);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_byte: got %03h, required no byte (t=%0t)", got, $time);
                    end else begin
                        exp = sb.pop_front();
                        check("frame_byte", got, exp);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_byte  = {out_last, out_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int valid_cycles;
        reset      = 1'b0;
        clear      = 1'b0;
        capture    = 1'b0;
        EvenParity = 8'h00;
        GreyCode   = 8'h00;
        overflow   = 1'b0;
        out_ready  = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", out_valid, 1'b0);
        check("rst_last",  out_last,  1'b0);
        check("rst_data",  out_data,  8'h00);
        check("rst_full",  fifo_full, 1'b0);
        check("rst_drop",  drop_count, 8'h00);

        // 1: single frame, header one cycle after the capture edge
        out_ready = 1'b1;
        push_frame(8'h05, 8'h07, 8'h00);
        do_capture(8'h05, 8'h07, 1'b0, 1'b0);
        check("s1_valid_at_k", out_valid, 1'b0);
        tick();
        check("s1_hdr", {out_valid, out_last, out_data}, {1'b1, 1'b0, 8'hA5});
        tick();
        check("s1_par", {out_valid, out_last, out_data}, {1'b1, 1'b0, 8'h05});
        tick();
        check("s1_gry", {out_valid, out_last, out_data}, {1'b1, 1'b0, 8'h07});
        tick();
        check("s1_trl", {out_valid, out_last, out_data}, {1'b1, 1'b1, 8'h00});
        tick();
        check("s1_idle", out_valid, 1'b0);
        check("s1_drain", sb.size(), 0);

        // 2: backpressure on byte 2 (seq is now 1)
        push_frame(8'h05, 8'h07, 8'h01);
        do_capture(8'h05, 8'h07, 1'b0, 1'b0);
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s2_hold", {out_valid, out_data}, {1'b1, 8'h05});
        end
        out_ready = 1'b1;
        wait_drain(10);

        // 3: overflow/drop; the first capture moves straight into the frame register
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 5)
                push_frame(8'h10 + 8'(i), 8'h20 + 8'(i), 8'(i));
            do_capture(8'h10 + 8'(i), 8'h20 + 8'(i), 1'b0, 1'b0);
            if (i == 3) check("s3_not_full_4", fifo_full, 1'b0);
            if (i == 4) check("s3_full_5", fifo_full, 1'b1);
        end
        check("s3_full", fifo_full, 1'b1);
        check("s3_drop", drop_count, 8'd2);
        out_ready    = 1'b1;
        valid_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) valid_cycles++;
            tick();
        end
        check("s3_back_to_back", valid_cycles, 20);
        check("s3_idle_after", out_valid, 1'b0);
        check("s3_not_full", fifo_full, 1'b0);
        check("s3_drain", sb.size(), 0);

        // 4: seq wrap after 16 frames, then drop_count saturation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push_frame(8'(i), ~8'(i), {4'h0, 4'(i)});
            do_capture(8'(i), ~8'(i), 1'b0, 1'b0);
            wait_drain(20);
        end
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++)
            push_frame(8'h3C, 8'hC3, 8'h01 + 8'(j));
        capture    = 1'b1;
        EvenParity = 8'h3C;
        GreyCode   = 8'hC3;
        overflow   = 1'b0;
        for (int j = 0; j < 300; j++)
            tick();
        check("s4_drop_sat", drop_count, 8'hFF);
        for (int j = 0; j < 4; j++)
            tick();
        capture = 1'b0;
        check("s4_drop_hold", drop_count, 8'hFF);
        out_ready = 1'b1;
        wait_drain(40);

        // 5: overflow bit in trailer, clear, capture alongside clear
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_frame(8'h40 + 8'(i), 8'h50 + 8'(i), 8'(i));
            do_capture(8'h40 + 8'(i), 8'h50 + 8'(i), 1'b0, 1'b0);
            wait_drain(20);
        end
        push_frame(8'hAA, 8'h55, 8'h83);
        do_capture(8'hAA, 8'h55, 1'b1, 1'b0);
        wait_drain(20);
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 5)
                push_frame(8'h60 + 8'(i), 8'h70 + 8'(i), 8'h04 + 8'(i));
            do_capture(8'h60 + 8'(i), 8'h70 + 8'(i), 1'b0, 1'b0);
        end
        check("s5_drop_pre", drop_count, 8'd2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("s5_drop_clr", drop_count, 8'd0);
        check("s5_full_kept", fifo_full, 1'b1);
        out_ready = 1'b1;
        wait_drain(40);
        push_frame(8'h81, 8'h82, 8'h00);
        do_capture(8'h81, 8'h82, 1'b0, 1'b0);
        wait_drain(20);
        push_frame(8'h83, 8'h84, 8'h01);
        do_capture(8'h83, 8'h84, 1'b0, 1'b1);
        wait_drain(20);
        push_frame(8'h85, 8'h86, 8'h80);
        do_capture(8'h85, 8'h86, 1'b1, 1'b0);
        wait_drain(20);

        // 6: reset after the header transfer abandons the frame and empties the FIFO
        do_reset();
        out_ready = 1'b1;
        sb.push_back({1'b0, 8'hA5});
        do_capture(8'h91, 8'h92, 1'b0, 1'b0);
        do_capture(8'h93, 8'h94, 1'b0, 1'b0);
        do_capture(8'h95, 8'h96, 1'b0, 1'b0);
        check("s6_par_shown", {out_valid, out_data}, {1'b1, 8'h91});
        reset     = 1'b0;
        out_ready = 1'b0;
        tick();
        check("s6_valid_rst", out_valid, 1'b0);
        check("s6_full_rst", fifo_full, 1'b0);
        check("s6_data_rst", out_data, 8'h00);
        reset     = 1'b1;
        out_ready = 1'b1;
        valid_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) valid_cycles++;
        end
        check("s6_no_residue", valid_cycles, 0);
        check("s6_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
